// File: rtl/motor_ctrl_fsm_p.sv
// Control FSM for the stepper-motor instruction processor: fetch/decode/execute,
// move-loop counter and delay timer. Define MOTOR_CTRL_ABORT_EN to add the abort input.
module motor_ctrl_fsm_p #(
  parameter int DATA_W      = 8,
  parameter int DELAY_W     = 20,
  parameter int STEP_DELAY  = 250000,
  parameter int PAUSE_DELAY = 500000,
  parameter int STEP_FULL   = 2,
  parameter int STEP_HALF   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef MOTOR_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic [3:0]        opcode,
  input  logic              r0_is_zero,
  input  logic [DATA_W-1:0] move_count,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              reg_we,
  output logic [1:0]        reg_waddr,
  output logic              result_sel,
  output logic [1:0]        op1_sel,
  output logic [1:0]        op2_sel,
  output logic [1:0]        imm_sel,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] step_const,
  output logic              busy,
  output logic              illegal_op,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_MOVE_LOAD  = 4'd4,
    S_MOVE_STEP  = 4'd5,
    S_MOVE_WAIT  = 4'd6,
    S_PAUSE_WAIT = 4'd7
  } state_t;

  localparam logic [3:0] OP_BR     = 4'd0;
  localparam logic [3:0] OP_BRZ    = 4'd1;
  localparam logic [3:0] OP_ADDI   = 4'd2;
  localparam logic [3:0] OP_SUBI   = 4'd3;
  localparam logic [3:0] OP_SR0    = 4'd4;
  localparam logic [3:0] OP_SRH0   = 4'd5;
  localparam logic [3:0] OP_CLR    = 4'd6;
  localparam logic [3:0] OP_MOV    = 4'd7;
  localparam logic [3:0] OP_MOVR   = 4'd8;
  localparam logic [3:0] OP_MOVRHS = 4'd9;
  localparam logic [3:0] OP_PAUSE  = 4'd10;

  localparam logic [DELAY_W-1:0] STEP_LOAD  = DELAY_W'(STEP_DELAY - 1);
  localparam logic [DELAY_W-1:0] PAUSE_LOAD = DELAY_W'(PAUSE_DELAY - 1);
  localparam logic [DATA_W-1:0]  FULL_C     = DATA_W'(STEP_FULL);
  localparam logic [DATA_W-1:0]  HALF_C     = DATA_W'(STEP_HALF);

  state_t                    state_q;
  logic [3:0]                op_q;
  logic signed [DATA_W-1:0]  cnt;
  logic [DELAY_W-1:0]        timer;
  logic                      abort_hit;
  logic                      cnt_zero;
  logic                      cnt_neg;

  assign cnt_zero = (cnt == '0);
  assign cnt_neg  = cnt[DATA_W-1];
  assign state    = state_q;

`ifdef MOTOR_CTRL_ABORT_EN
  assign abort_hit = abort & ((state_q == S_MOVE_STEP) | (state_q == S_MOVE_WAIT) |
                              (state_q == S_PAUSE_WAIT));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      op_q    <= '0;
      cnt     <= '0;
      timer   <= '0;
    end else if (abort_hit) begin
      cnt     <= '0;
      timer   <= '0;
      state_q <= S_FETCH;
    end else begin
      unique case (state_q)
        S_RESET:  state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          if (opcode == OP_MOVR || opcode == OP_MOVRHS) begin
            state_q <= S_MOVE_LOAD;
          end else if (opcode == OP_PAUSE) begin
            timer   <= PAUSE_LOAD;
            state_q <= S_PAUSE_WAIT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: state_q <= S_FETCH;
        S_MOVE_LOAD: begin
          cnt     <= $signed(move_count);
          state_q <= S_MOVE_STEP;
        end
        S_MOVE_STEP: begin
          if (cnt_zero) begin
            state_q <= S_FETCH;
          end else begin
            // Step toward zero by +/-1 so -2^(DATA_W-1) never needs negating.
            cnt     <= cnt_neg ? cnt + DATA_W'(1) : cnt - DATA_W'(1);
            timer   <= STEP_LOAD;
            state_q <= S_MOVE_WAIT;
          end
        end
        S_MOVE_WAIT: begin
          if (timer == '0) state_q <= S_MOVE_STEP;
          else             timer   <= timer - DELAY_W'(1);
        end
        S_PAUSE_WAIT: begin
          if (timer == '0) state_q <= S_FETCH;
          else             timer   <= timer - DELAY_W'(1);
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  always_comb begin
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    reg_we     = 1'b0;
    reg_waddr  = 2'd0;
    result_sel = 1'b0;
    op1_sel    = 2'd0;
    op2_sel    = 2'd0;
    imm_sel    = 2'd0;
    alu_op     = 2'd0;
    step_const = '0;
    busy       = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      S_EXEC: begin
        busy = 1'b1;
        case (op_q)
          OP_ADDI, OP_SUBI: begin
            reg_we     = 1'b1;
            reg_waddr  = 2'd1;
            op1_sel    = 2'd1;
            op2_sel    = 2'd1;
            imm_sel    = 2'd0;
            alu_op     = (op_q == OP_SUBI) ? 2'd1 : 2'd0;
            result_sel = 1'b1;
            pc_inc     = 1'b1;
          end
          OP_SR0, OP_SRH0: begin
            reg_we     = 1'b1;
            reg_waddr  = 2'd0;
            op1_sel    = 2'd3;
            op2_sel    = 2'd1;
            imm_sel    = 2'd1;
            alu_op     = (op_q == OP_SRH0) ? 2'd3 : 2'd2;
            result_sel = 1'b1;
            pc_inc     = 1'b1;
          end
          OP_CLR: begin
            reg_we    = 1'b1;
            reg_waddr = 2'd1;
            pc_inc    = 1'b1;
          end
          OP_MOV: begin
            reg_we     = 1'b1;
            reg_waddr  = 2'd2;
            op1_sel    = 2'd1;
            op2_sel    = 2'd1;
            imm_sel    = 2'd3;
            result_sel = 1'b1;
            pc_inc     = 1'b1;
          end
          OP_BR, OP_BRZ: begin
            if (op_q == OP_BR || r0_is_zero) begin
              pc_load = 1'b1;
              op1_sel = 2'd0;
              op2_sel = 2'd1;
              imm_sel = 2'd2;
            end else begin
              pc_inc = 1'b1;
            end
          end
          default: begin
            pc_inc     = 1'b1;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MOVE_LOAD: busy = 1'b1;
      S_MOVE_STEP: begin
        busy = 1'b1;
        if (abort_hit || cnt_zero) begin
          pc_inc = 1'b1;
        end else begin
          step_const = (op_q == OP_MOVRHS) ? HALF_C : FULL_C;
          reg_we     = 1'b1;
          reg_waddr  = 2'd2;
          op1_sel    = 2'd2;
          op2_sel    = 2'd2;
          result_sel = 1'b1;
          alu_op     = cnt_neg ? 2'd1 : 2'd0;
        end
      end
      S_MOVE_WAIT: begin
        busy   = 1'b1;
        pc_inc = abort_hit;
      end
      S_PAUSE_WAIT: begin
        busy   = 1'b1;
        pc_inc = abort_hit | (timer == '0);
      end
      default: ;
    endcase
  end

endmodule
